riscv_fetch_seq: RTL and testbench
==================================

RISCV_FETCH_SEQ -- requirements
Module: riscv_fetch_seq

Interface
REQ-001 The block SHALL provide parameter WORD_LENGTH, default 32, meaning data and address width.
REQ-002 The block SHALL provide parameter PC_OFFSET, default 4, meaning sequential PC increment.
REQ-003 The block SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, meaning first fetch address.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port x_reset, input, 1, reset: synchronous, active-low.
REQ-006 The block SHALL have port trap_valid, input, 1, trap/ecall redirect request.
REQ-007 The block SHALL have port mtvec_addr, input, WORD_LENGTH, trap target.
REQ-008 The block SHALL have port redirect_valid, input, 1, taken branch/jump request.
REQ-009 The block SHALL have port redirect_addr, input, WORD_LENGTH, branch/jump target.
REQ-010 The block SHALL have port imem_req, output, 1, instruction memory request.
REQ-011 The block SHALL have port imem_addr, output, WORD_LENGTH, fetch address.
REQ-012 The block SHALL have port imem_ack, input, 1, memory response valid; one ack per request.
REQ-013 The block SHALL have port imem_rdata, input, WORD_LENGTH, fetched instruction.
REQ-014 The block SHALL have port inst_valid, output, 1, instruction available downstream.
REQ-015 The block SHALL have port inst_ready, input, 1, downstream accepts the instruction.
REQ-016 The block SHALL have port inst, output, WORD_LENGTH, held instruction.
REQ-017 The block SHALL have port inst_pc, output, WORD_LENGTH, address of inst.
REQ-018 The block SHALL have port fetch_count, output, 32, count of instructions accepted downstream.

Function
REQ-019 The FSM SHALL have states START, FETCH and HOLD; START lasts exactly one cycle after reset release, then moves to FETCH.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL be the current pc; imem_addr SHALL stay stable until imem_ack.
REQ-021 In FETCH on imem_ack with no pending flush, the block SHALL register inst=imem_rdata and inst_pc=pc, set pc=pc+PC_OFFSET, and enter HOLD.
REQ-022 In HOLD, inst_valid SHALL be 1 and inst/inst_pc SHALL be stable; on inst_ready the block SHALL return to FETCH the next cycle and increment fetch_count.
REQ-023 Redirect priority SHALL be trap_valid over redirect_valid; target bits [1:0] SHALL be forced to 0.
REQ-024 A redirect in HOLD SHALL discard the held instruction (inst_valid 0 next cycle), load pc with the target and enter FETCH; if inst_ready is also 1, fetch_count SHALL still increment.
REQ-025 A redirect in FETCH without imem_ack SHALL latch the target in a pending register (a later, higher-priority redirect overwrites it); when the ack arrives, the response SHALL be dropped, pc SHALL load the pending target, and the state SHALL remain FETCH.
REQ-026 A redirect in the same cycle as imem_ack SHALL drop that response and load pc with the redirect target.
REQ-027 A redirect in START SHALL load pc with the target before the first fetch.
REQ-028 Latency: imem_ack to inst_valid SHALL be 1 cycle; inst_ready to the next imem_req SHALL be 1 cycle.
REQ-029 pc and fetch_count SHALL wrap modulo 2^WORD_LENGTH and 2^32 respectively.
REQ-030 Each pc update SHALL add PC_OFFSET at WORD_LENGTH bits, discarding carry-out.

Reset
REQ-031 With x_reset=0 at a rising edge, the block SHALL enter START, set pc=RESET_VECTOR, clear pending, inst=0, inst_pc=0 and fetch_count=0; imem_req and inst_valid SHALL be 0 from the following cycle.
REQ-032 Reset during FETCH or HOLD SHALL abandon the transaction; an imem_ack arriving in START SHALL be ignored.

Verification
REQ-033 Bench SHALL cover basic flow: reset release, ack after 2 cycles with rdata=32'h00000013, inst_ready=1 -> addrs 0x0,0x4,0x8 fetched; inst_pc 0x0 with inst 0x00000013; fetch_count=3.
REQ-034 Bench SHALL cover backpressure: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable; imem_req=0 throughout.
REQ-035 Bench SHALL cover redirect while waiting: redirect_addr=0x100 in FETCH at pc=0x8, ack 3 cycles later -> response dropped; next imem_addr=0x100; no inst_valid for 0x8.
REQ-036 Bench SHALL cover simultaneous requests: trap_valid with mtvec_addr=0x200 and redirect_valid with 0x300 in HOLD -> next imem_addr=0x200.
REQ-037 Bench SHALL cover misaligned targets and wrap: redirect_addr=0x103 -> imem_addr=0x100; pc=0xFFFFFFFC ack -> next imem_addr=0x0.
REQ-038 Bench SHALL cover reset mid-operation: x_reset=0 in HOLD with fetch_count=7 -> fetch_count=0, inst_valid=0; first fetch after START at 0x0.

Source files
------------

// File: rtl/riscv_fetch_seq_if.sv
// Fetch-side bus bundle for riscv_fetch_seq.
// It carries the instruction memory request/ack pair and the downstream valid/ready pair.
interface riscv_fetch_seq_if #(
  parameter int unsigned WORD_LENGTH = 32
);
  logic                   imem_req;
  logic [WORD_LENGTH-1:0] imem_addr;
  logic                   imem_ack;
  logic [WORD_LENGTH-1:0] imem_rdata;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [WORD_LENGTH-1:0] inst;
  logic [WORD_LENGTH-1:0] inst_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/riscv_fetch_seq.sv
// Sequential RISC-V instruction fetch: one outstanding imem request, a one-entry hold
// register toward decode, and trap/branch redirects that can arrive at any point.
module riscv_fetch_seq #(
  parameter int unsigned            WORD_LENGTH  = 32,
  parameter int unsigned            PC_OFFSET    = 4,
  parameter logic [WORD_LENGTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   x_reset,
  input  logic                   trap_valid,
  input  logic [WORD_LENGTH-1:0] mtvec_addr,
  input  logic                   redirect_valid,
  input  logic [WORD_LENGTH-1:0] redirect_addr,
  riscv_fetch_seq_if.master      bus,
  output logic [31:0]            fetch_count
);

  localparam logic [WORD_LENGTH-1:0] PcIncr    = WORD_LENGTH'(PC_OFFSET);
  localparam logic [WORD_LENGTH-1:0] AlignMask = ~WORD_LENGTH'(3);

  typedef enum logic [1:0] {
    StStart,
    StFetch,
    StHold
  } state_e;

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] pc_q, pc_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [WORD_LENGTH-1:0] pend_addr_q, pend_addr_d;
  logic [WORD_LENGTH-1:0] inst_q, inst_d;
  logic [WORD_LENGTH-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]            count_q, count_d;

  logic                   redir_any;
  logic [WORD_LENGTH-1:0] redir_raw;
  logic [WORD_LENGTH-1:0] redir_target;

  // Trap wins over branch; targets are forced word aligned.
  always_comb begin
    redir_any    = trap_valid | redirect_valid;
    redir_raw    = trap_valid ? mtvec_addr : redirect_addr;
    redir_target = redir_raw & AlignMask;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    count_d      = count_q;

    unique case (state_q)
      StStart: begin
        // Any ack seen here belongs to a transaction abandoned by reset.
        state_d = StFetch;
        if (redir_any) begin
          pc_d = redir_target;
        end
      end

      StFetch: begin
        if (redir_any && bus.imem_ack) begin
          pc_d         = redir_target;
          pend_valid_d = 1'b0;
        end else if (redir_any) begin
          // Address must stay put until the ack, so park the target.
          pend_valid_d = 1'b1;
          pend_addr_d  = redir_target;
        end else if (bus.imem_ack) begin
          if (pend_valid_q) begin
            pc_d         = pend_addr_q;
            pend_valid_d = 1'b0;
          end else begin
            inst_d    = bus.imem_rdata;
            inst_pc_d = pc_q;
            pc_d      = pc_q + PcIncr;
            state_d   = StHold;
          end
        end
      end

      StHold: begin
        if (bus.inst_ready) begin
          count_d = count_q + 32'd1;
        end
        if (redir_any) begin
          pc_d    = redir_target;
          state_d = StFetch;
        end else if (bus.inst_ready) begin
          state_d = StFetch;
        end
      end

      default: begin
        state_d = StStart;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!x_reset) begin
      state_q      <= StStart;
      pc_q         <= RESET_VECTOR;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      count_q      <= count_d;
    end
  end

  assign bus.imem_req   = (state_q == StFetch);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (state_q == StHold);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_riscv_fetch_seq.sv
// Self-checking bench for riscv_fetch_seq: directed scenarios with a scoreboard of
// {pc, instruction} pairs that must appear downstream in order.
module tb_riscv_fetch_seq;

  logic        clk;
  logic        x_reset;
  logic        trap_valid;
  logic [31:0] mtvec_addr;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] fetch_count;

  riscv_fetch_seq_if #(.WORD_LENGTH(32)) bus ();

  riscv_fetch_seq #(
    .WORD_LENGTH (32),
    .PC_OFFSET   (4),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .x_reset       (x_reset),
    .trap_valid    (trap_valid),
    .mtvec_addr    (mtvec_addr),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .bus           (bus),
    .fetch_count   (fetch_count)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Downstream handshake happens at the next edge; compare against the oldest expectation.
  always @(negedge clk) begin
    if (bus.inst_valid && bus.inst_ready && x_reset) begin
      logic [63:0] e;
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("inst_pc", bus.inst_pc, e[63:32]);
        check("inst", bus.inst, e[31:0]);
      end
    end
  end

  // Wait for a request, hold it for lat cycles, then ack it with rdata.
  task automatic serve(input int lat, input logic [31:0] exp_addr, input logic [31:0] rdata,
                       input bit expect_inst);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    check("req_seen", 32'(bus.imem_req), 32'd1);
    check("imem_addr", bus.imem_addr, exp_addr);
    for (int i = 0; i < lat; i++) begin
      step();
      check("addr_stable", bus.imem_addr, exp_addr);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    if (expect_inst) sb_q.push_back({exp_addr, rdata});
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
  endtask

  task automatic redirect(input bit trap, input logic [31:0] addr);
    if (trap) begin
      trap_valid = 1'b1;
      mtvec_addr = addr;
    end else begin
      redirect_valid = 1'b1;
      redirect_addr  = addr;
    end
  endtask

  task automatic clear_redirect();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    x_reset        = 1'b0;
    trap_valid     = 1'b0;
    mtvec_addr     = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);

    // Basic flow: START for one cycle, then 0x0, 0x4, 0x8
    x_reset = 1'b1;
    check("start_req", 32'(bus.imem_req), 32'd0);
    step();
    check("first_req", 32'(bus.imem_req), 32'd1);
    bus.inst_ready = 1'b1;
    serve(2, 32'h0, 32'h0000_0013, 1'b1);
    check("hold_inst_pc", bus.inst_pc, 32'h0);
    check("hold_inst", bus.inst, 32'h0000_0013);
    serve(2, 32'h4, 32'h0000_0013, 1'b1);
    serve(2, 32'h8, 32'h0000_0013, 1'b1);
    step();
    check("basic_count", fetch_count, 32'd3);

    // Backpressure: held instruction stays put, no new request
    bus.inst_ready = 1'b0;
    serve(1, 32'hC, 32'h0050_0093, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.inst_valid), 32'd1);
      check("bp_req", 32'(bus.imem_req), 32'd0);
      check("bp_inst", bus.inst, 32'h0050_0093);
      check("bp_inst_pc", bus.inst_pc, 32'hC);
      step();
    end
    bus.inst_ready = 1'b1;
    step();
    check("bp_next_req", 32'(bus.imem_req), 32'd1);
    check("bp_next_addr", bus.imem_addr, 32'h10);
    check("bp_count", fetch_count, 32'd4);

    // Build up to fetch_count=7 with an instruction held, then reset
    serve(0, 32'h10, 32'h0000_1111, 1'b1);
    serve(0, 32'h14, 32'h0000_2222, 1'b1);
    serve(0, 32'h18, 32'h0000_3333, 1'b1);
    step();
    bus.inst_ready = 1'b0;
    serve(0, 32'h1C, 32'h0000_4444, 1'b0);
    check("pre_rst_valid", 32'(bus.inst_valid), 32'd1);
    check("pre_rst_count", fetch_count, 32'd7);
    x_reset = 1'b0;
    step();
    check("mid_rst_count", fetch_count, 32'd0);
    check("mid_rst_valid", 32'(bus.inst_valid), 32'd0);
    check("mid_rst_req", 32'(bus.imem_req), 32'd0);
    x_reset = 1'b1;
    step();
    check("post_rst_addr", bus.imem_addr, 32'h0);

    // Redirect while waiting at pc=0x8: response dropped, then fetch 0x100
    bus.inst_ready = 1'b1;
    serve(0, 32'h0, 32'h0000_0013, 1'b1);
    serve(0, 32'h4, 32'h0000_0013, 1'b1);
    step();
    check("rw_addr", bus.imem_addr, 32'h8);
    redirect(1'b0, 32'h100);
    step();
    clear_redirect();
    check("rw_stable1", bus.imem_addr, 32'h8);
    step();
    check("rw_stable2", bus.imem_addr, 32'h8);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_0008;
    step();
    bus.imem_ack   = 1'b0;
    check("rw_valid", 32'(bus.inst_valid), 32'd0);
    check("rw_new_addr", bus.imem_addr, 32'h100);

    // Trap beats branch while holding
    bus.inst_ready = 1'b0;
    serve(0, 32'h100, 32'h0000_0073, 1'b0);
    check("sim_hold_pc", bus.inst_pc, 32'h100);
    redirect(1'b1, 32'h200);
    redirect(1'b0, 32'h300);
    step();
    clear_redirect();
    check("sim_valid", 32'(bus.inst_valid), 32'd0);
    check("sim_addr", bus.imem_addr, 32'h200);

    // Redirect with ack in the same cycle, misaligned targets, pc wrap
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_0200;
    redirect(1'b0, 32'h103);
    step();
    clear_redirect();
    bus.imem_ack = 1'b0;
    check("mis_valid", 32'(bus.inst_valid), 32'd0);
    check("mis_addr", bus.imem_addr, 32'h100);
    bus.imem_ack = 1'b1;
    redirect(1'b0, 32'hFFFF_FFFF);
    step();
    clear_redirect();
    bus.imem_ack = 1'b0;
    check("wrap_start", bus.imem_addr, 32'hFFFF_FFFC);
    bus.inst_ready = 1'b1;
    serve(0, 32'hFFFF_FFFC, 32'h0010_0073, 1'b1);
    step();
    check("wrap_addr", bus.imem_addr, 32'h0);
    check("wrap_count", fetch_count, 32'd3);

    // A later trap overwrites a pending branch target
    redirect(1'b0, 32'h80);
    step();
    clear_redirect();
    redirect(1'b1, 32'hC0);
    step();
    clear_redirect();
    check("pend_stable", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("pend_addr", bus.imem_addr, 32'hC0);
    check("pend_valid", 32'(bus.inst_valid), 32'd0);

    // Redirect in START; a stray ack there is ignored
    x_reset = 1'b0;
    step();
    check("rst2_inst", bus.inst, 32'd0);
    check("rst2_inst_pc", bus.inst_pc, 32'd0);
    x_reset = 1'b1;
    redirect(1'b0, 32'h40);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_0000;
    check("start2_req", 32'(bus.imem_req), 32'd0);
    step();
    clear_redirect();
    bus.imem_ack = 1'b0;
    check("start2_req_on", 32'(bus.imem_req), 32'd1);
    check("start2_addr", bus.imem_addr, 32'h40);
    check("start2_valid", 32'(bus.inst_valid), 32'd0);
    serve(0, 32'h40, 32'h0000_0013, 1'b1);
    step();
    check("start2_count", fetch_count, 32'd1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
